// File: rtl/ncl_rx_pkg.sv
// Shared definitions for the NCL dual-rail receiver: rail codes, channel
// state encoding and small decode helpers.
package ncl_rx_pkg;

   // Two-rail code as seen after synchronization: {rail1 (TRUE), rail0 (FALSE)}
   localparam logic [1:0] RAIL_NULL    = 2'b00;
   localparam logic [1:0] RAIL_DATA0   = 2'b01;
   localparam logic [1:0] RAIL_DATA1   = 2'b10;
   localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

   // Per-channel handshake state. Ack is high in CAPT/DRAIN, slot is full in CAPT/FULL.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_CAPT  = 2'b01,
      ST_FULL  = 2'b10,
      ST_DRAIN = 2'b11
   } chan_state_t;

   // True when the code carries a valid data bit (exactly one rail high)
   function automatic logic rail_is_data(input logic [1:0] code);
      return (code == RAIL_DATA0) || (code == RAIL_DATA1);
   endfunction

   // True when the code is the NULL spacer
   function automatic logic rail_is_null(input logic [1:0] code);
      return (code == RAIL_NULL);
   endfunction

   // True when both rails are high, which no correct NCL stage produces
   function automatic logic rail_is_illegal(input logic [1:0] code);
      return (code == RAIL_ILLEGAL);
   endfunction

endpackage

// File: rtl/digit_counter_reader_if.sv
// Word-delivery bus between the receiver and the clocked consumer.
// The receiver (master) presents value/ovf with valid; the consumer
// (slave) accepts with ready.
interface digit_counter_reader_if #(
   parameter int DIGITS = 32
);
   logic [DIGITS-1:0] value;
   logic              ovf;
   logic              valid;
   logic              ready;

   modport master (
      output value,
      output ovf,
      output valid,
      input  ready
   );

   modport slave (
      input  value,
      input  ovf,
      input  valid,
      output ready
   );
endinterface

// File: rtl/ncl_rx_channel.sv
// One dual-rail receive channel: rail synchronizer, four-state handshake
// FSM, one captured data bit and a combinational illegal-code pulse.
module ncl_rx_channel
   import ncl_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_init,
   input  logic [1:0] i_rails,
   input  logic       i_accept,
   output logic       o_ack,
   output logic       o_full,
   output logic       o_bit,
   output logic       o_err
);

   logic [1:0]  r_sync [SYNC_STAGES];
   chan_state_t r_state;
   logic        r_bit;

   logic [1:0]  w_code;
   chan_state_t w_state_nxt;
   logic        w_bit_nxt;

   // Rail synchronizer; deliberately not reset so in-flight data survives init
   always_ff @(posedge i_clk) begin
      r_sync[0] <= i_rails;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         r_sync[k] <= r_sync[k-1];
      end
   end

   assign w_code = r_sync[SYNC_STAGES-1];

   // Next-state and capture logic; word accept outranks any rail event
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      case (r_state)
         ST_EMPTY: begin
            if (rail_is_data(w_code)) begin
               w_state_nxt = ST_CAPT;
               w_bit_nxt   = w_code[1];
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_CAPT: begin
            if (i_accept) begin
               w_state_nxt = ST_DRAIN;
            end else if (rail_is_null(w_code)) begin
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_CAPT;
            end
         end
         ST_FULL: begin
            if (i_accept) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_DRAIN: begin
            if (rail_is_null(w_code)) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // State and captured bit registers with synchronous init
   always_ff @(posedge i_clk) begin
      if (i_init) begin
         r_state <= ST_EMPTY;
         r_bit   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

   assign o_ack  = (r_state == ST_CAPT) || (r_state == ST_DRAIN);
   assign o_full = (r_state == ST_CAPT) || (r_state == ST_FULL);
   assign o_bit  = r_bit;
   assign o_err  = rail_is_illegal(w_code);

endmodule

// File: rtl/digit_counter_reader.sv
// Clocked receiver for the dual-rail NCL digit counter ring. Runs one
// channel per digit plus one for the carry, and releases a binary word
// once every channel holds a captured bit.
module digit_counter_reader
   import ncl_rx_pkg::*;
#(
   parameter int DIGITS      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  init,
   input  logic [2*DIGITS-1:0]   sum_rails,
   input  logic [1:0]            carry_rails,
   output logic [DIGITS-1:0]     sumcomp,
   output logic                  carrycomp,
   output logic                  rail_err,
   digit_counter_reader_if.master bus
);

   // Carry is treated as channel DIGITS, one past the top digit
   logic [2*DIGITS+1:0] w_all_rails;
   logic [DIGITS:0]     w_ack;
   logic [DIGITS:0]     w_full;
   logic [DIGITS:0]     w_bit;
   logic [DIGITS:0]     w_err;
   logic                w_valid;
   logic                w_accept;
   logic                r_rail_err;

   assign w_all_rails = {carry_rails, sum_rails};

   for (genvar g = 0; g <= DIGITS; g++) begin : g_chan
      ncl_rx_channel #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .i_clk    (clk),
         .i_init   (init),
         .i_rails  (w_all_rails[2*g +: 2]),
         .i_accept (w_accept),
         .o_ack    (w_ack[g]),
         .o_full   (w_full[g]),
         .o_bit    (w_bit[g]),
         .o_err    (w_err[g])
      );
   end

   // A word is complete only when every slot is full; built from FSM state only
   assign w_valid  = &w_full;
   assign w_accept = w_valid & bus.ready;

   // Sticky illegal-code flag, cleared only by init
   always_ff @(posedge clk) begin
      if (init) begin
         r_rail_err <= 1'b0;
      end else begin
         r_rail_err <= r_rail_err | (|w_err);
      end
   end

   assign bus.valid = w_valid;
   assign bus.value = w_bit[DIGITS-1:0];
   assign bus.ovf   = w_bit[DIGITS];
   assign sumcomp   = w_ack[DIGITS-1:0];
   assign carrycomp = w_ack[DIGITS];
   assign rail_err  = r_rail_err;

endmodule
